// File: rtl/mul_acc_sequencer_pkg.sv
// Shared types and default widths for the multiply-accumulate sequencer.
package mul_acc_sequencer_pkg;

   localparam int ACC_W_DEF = 24;
   localparam int LEN_W_DEF = 8;
   localparam int PROD_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/mul_acc_sequencer_mac_accumulator.sv
// Wide accumulator for 16-bit products with a sticky carry-out flag.
module mac_accumulator
   import mul_acc_sequencer_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [PROD_W-1:0] p,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sum;

   // One extra bit catches the carry out of the modular sum.
   assign sum = {1'b0, acc_q} + (ACC_W + 1)'(p);

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (en) begin
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_q | sum[ACC_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/mul_acc_sequencer.sv
// Feeds operand pairs into an external combinational multiplier and sums a burst of products.
module mul_acc_sequencer
   import mul_acc_sequencer_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_a,
   input  logic [7:0]        in_b,
   output logic [7:0]        mul_a,
   output logic [7:0]        mul_b,
   input  logic [PROD_W-1:0] mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic              busy
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [7:0]       mul_a_q, mul_a_d;
   logic [7:0]       mul_b_q, mul_b_d;
   logic             p_vld_q, p_vld_d;
   logic             acc_clr, acc_en, hs;

   assign in_ready = (state_q == ST_RUN) && (cnt_q < len_q);
   assign hs       = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      p_vld_d = p_vld_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d   = len;
               cnt_d   = '0;
               p_vld_d = 1'b0;
               acc_clr = 1'b1;
               state_d = (len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // A new pair may land in the operand registers on the same edge
            // the previous product is accumulated, giving one pair per cycle.
            acc_en  = p_vld_q;
            p_vld_d = hs;
            if (hs) begin
               mul_a_d = in_a;
               mul_b_d = in_b;
               cnt_d   = cnt_q + 1'b1;
            end
            if (p_vld_q && !hs && (cnt_q == len_q))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         p_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         p_vld_q <= p_vld_d;
      end
   end

   mac_accumulator #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .p     (mul_p),
      .acc   (out_sum),
      .ovf   (out_ovf)
   );

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

endmodule
